// File: rtl/truth_table_equiv_checker.sv
// Exhaustive truth-table equivalence checker: one minterm per cycle,
// reports equality, first differing minterm and mismatch count.
module truth_table_equiv_checker #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              invert_b,
  input  logic [(1<<N)-1:0] tt_a,
  input  logic [(1<<N)-1:0] tt_b,
  output logic [N-1:0]      x,
  output logic              busy,
  output logic              done,
  output logic              equal,
  output logic [N-1:0]      first_mismatch,
  output logic [N:0]        mismatch_count
);

  localparam int M = 1 << N;
  localparam logic [N-1:0] LAST = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic           inv_q, inv_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [N:0]     cnt_q, cnt_d;
  logic [N-1:0]   first_q, first_d;
  logic           found_q, found_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           equal_q, equal_d;
  logic [N-1:0]   fm_q, fm_d;
  logic [N:0]     mc_q, mc_d;
  logic           mis;

  assign mis = a_q[idx_q] ^ b_q[idx_q] ^ inv_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    inv_d   = inv_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    found_d = found_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    equal_d = equal_q;
    fm_d    = fm_q;
    mc_d    = mc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          a_d     = tt_a;
          b_d     = tt_b;
          inv_d   = invert_b;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = '0;
          found_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SCAN: begin
        if (mis) begin
          cnt_d = cnt_q + (N+1)'(1);
          if (!found_q) begin
            found_d = 1'b1;
            first_d = idx_q;
          end
        end
        // Last minterm: publish results including this cycle's compare
        if (idx_q == LAST) begin
          state_d = S_DONE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equal_d = (cnt_d == '0);
          fm_d    = first_d;
          mc_d    = cnt_d;
        end else begin
          idx_d = idx_q + N'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      inv_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      fm_q    <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      found_q <= found_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      fm_q    <= fm_d;
      mc_q    <= mc_d;
    end
  end

  assign x              = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign equal          = equal_q;
  assign first_mismatch = fm_q;
  assign mismatch_count = mc_q;

endmodule

// File: doc/truth_table_equiv_checker.md
TRUTH_TABLE_EQUIV_CHECKER -- requirements
Module: truth_table_equiv_checker

Interface
REQ-001 Parameter N, default 4, legal 1..8: number of function inputs x1..xN.
REQ-002 Clock  input  1  rising-edge clock, sole clock domain.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin one exhaustive comparison.
REQ-005 invert_b  input  1  mode: 0 compares f1 against f2, 1 compares f1 against ~f2.
REQ-006 tt_a  input  2^N  truth table of f1; bit i = f1 value at minterm i.
REQ-007 tt_b  input  2^N  truth table of f2, same encoding as tt_a.
REQ-008 x  output  N  minterm index currently under evaluation; x[N-1] = x1, x[0] = xN.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse marking a completed scan.
REQ-011 equal  output  1  result: 1 = functions identical over all 2^N minterms.
REQ-012 first_mismatch  output  N  lowest minterm index where the functions differ; 0 when equal.
REQ-013 mismatch_count  output  N+1  number of differing minterms, range 0..2^N.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, SCAN, DONE.
REQ-015 IDLE -> SCAN on the rising edge sampling start=1; on that edge the block SHALL latch tt_a, tt_b and invert_b, clear the index to 0, and clear the internal count and first-mismatch flag.
REQ-016 start SHALL be honoured only in IDLE; it SHALL be ignored in SCAN and DONE.
REQ-017 Changes on tt_a, tt_b and invert_b after the start edge SHALL NOT affect the running scan.
REQ-018 In SCAN the block SHALL evaluate exactly one minterm per cycle, in ascending order 0..2^N-1; x SHALL equal the index being evaluated.
REQ-019 A minterm i mismatches when tt_a[i] != (tt_b[i] XOR invert_b).
REQ-020 On each mismatch the internal count SHALL increment by 1; the first mismatch index SHALL be captured once and held.
REQ-021 Count arithmetic SHALL be N+1 bits wide and SHALL NOT wrap: all 2^N minterms mismatching yields exactly 2^N.
REQ-022 The index SHALL NOT wrap inside a scan: the edge evaluating minterm 2^N-1 SHALL move the FSM to DONE.
REQ-023 busy SHALL be 1 for exactly 2^N cycles, starting the cycle after the start edge.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-025 equal, first_mismatch and mismatch_count SHALL update only on the edge entering DONE and hold until the next DONE entry or Reset.
REQ-026 During SCAN these result outputs SHALL keep their previous scan's values.
REQ-027 x SHALL be 0 in IDLE and DONE.
REQ-028 Latency: start sampled at edge E0; done SHALL be high in the cycle following edge E(2^N); the earliest next accepted start is at edge E(2^N+2).
REQ-029 If a mismatch occurs at minterm 2^N-1 only, it SHALL be counted and reported as first_mismatch.

Reset
REQ-030 Reset=1 at a rising edge SHALL force IDLE and drive busy, done, equal, x, first_mismatch and mismatch_count to 0, regardless of state.
REQ-031 Reset SHALL take priority over start.
REQ-032 Reset during SCAN SHALL abort the scan with no done pulse and no result update beyond the clear.
REQ-033 Result outputs are meaningful only after the first done pulse following Reset.

Verification (N=4 unless stated)
REQ-034 tt_a=tt_b=16'hA5C3, invert_b=0, start -> busy 16 cycles, single done pulse, equal=1, mismatch_count=0, first_mismatch=0.
REQ-035 tt_a=16'h00FF, tt_b=16'h00F7 -> equal=0, mismatch_count=1, first_mismatch=3.
REQ-036 tt_a=16'hFFFF, tt_b=16'h0000, invert_b=0 -> mismatch_count=16, first_mismatch=0; repeat with invert_b=1 -> equal=1, mismatch_count=0.
REQ-037 start held high for the whole scan with tt_a changed to 16'h0000 at scan cycle 5 -> results reflect the latched tables; exactly one done pulse; the next scan begins only after returning to IDLE.
REQ-038 Reset asserted during scan cycle 8 -> next cycle busy=0, x=0, all results 0, no done pulse; a following start completes normally.
REQ-039 N=1, tt_a=2'b10, tt_b=2'b01 -> busy 2 cycles, equal=0, mismatch_count=2, first_mismatch=0.
